// File: rtl/usb_tx_serializer.sv
//==============================================================================
// Module   : usb_tx_serializer
// Brief    : USB transmit serializer. Sends SYNC, PID, payload, CRC16 and EOP
//            with on-the-fly bit stuffing and NRZI. Macro USB_TX_ABORT_EN adds
//            an abort port that cuts the packet short with an EOP.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module usb_tx_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_hshake,
    input  logic        send_data,
    input  logic [3:0]  pid,
    input  logic [63:0] data,
`ifdef USB_TX_ABORT_EN
    input  logic        abort,
`endif
    output logic [1:0]  bus_out,
    output logic        bus_en,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [2:0]  c_S_IDLE    = 3'd0;
    localparam logic [2:0]  c_S_SYNC    = 3'd1;
    localparam logic [2:0]  c_S_PID     = 3'd2;
    localparam logic [2:0]  c_S_DATA    = 3'd3;
    localparam logic [2:0]  c_S_CRC     = 3'd4;
    localparam logic [2:0]  c_S_EOP     = 3'd5;

    localparam logic [1:0]  c_LINE_J    = 2'b10;
    localparam logic [1:0]  c_LINE_K    = 2'b01;
    localparam logic [1:0]  c_LINE_X    = 2'b00;

    localparam logic [15:0] c_CRC_POLY  = 16'h8005;
    localparam logic [15:0] c_CRC_INIT  = 16'hFFFF;
    localparam logic [2:0]  c_STUFF_RUN = 3'd6;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [2:0]  r_ones;
    logic [2:0]  w_ones_nxt;
    logic        r_line_j;
    logic        w_line_j_nxt;
    logic [15:0] r_crc;
    logic [15:0] w_crc_nxt;
    logic [63:0] r_data;
    logic [7:0]  r_pid_byte;
    logic        r_is_data;
    logic [1:0]  r_bus_out;
    logic [1:0]  w_bus_out_nxt;
    logic        r_bus_en;
    logic        w_bus_en_nxt;
    logic        r_tx_busy;
    logic        w_tx_busy_nxt;
    logic        r_tx_done;
    logic        w_tx_done_nxt;

    logic        w_req;
    logic        w_abort;
    logic        w_stuff;
    logic        w_raw;
    logic        w_last;
    logic        w_line_nrzi;
    logic        w_crc_fb;

    assign w_req = send_data | send_hshake;

`ifdef USB_TX_ABORT_EN
    assign w_abort = abort && (r_state != c_S_IDLE) && (r_state != c_S_EOP);
`else
    assign w_abort = 1'b0;
`endif

    // A stuffed zero is owed whenever six ones have gone out since PID entry.
    assign w_stuff = (r_ones == c_STUFF_RUN) &&
                     ((r_state == c_S_PID) || (r_state == c_S_DATA) ||
                      (r_state == c_S_CRC) || (r_state == c_S_EOP));

    // Raw bit for this cycle and whether it is the final bit of the field.
    always_comb begin
        w_raw  = 1'b0;
        w_last = 1'b0;
        case (r_state)
            c_S_SYNC: begin
                w_raw  = (r_cnt == 6'd7);
                w_last = (r_cnt == 6'd7);
            end
            c_S_PID: begin
                w_raw  = r_pid_byte[r_cnt[2:0]];
                w_last = (r_cnt == 6'd7);
            end
            c_S_DATA: begin
                w_raw  = r_data[r_cnt];
                w_last = (r_cnt == 6'd63);
            end
            c_S_CRC: begin
                w_raw  = ~r_crc[4'd15 - r_cnt[3:0]];
                w_last = (r_cnt == 6'd15);
            end
            c_S_EOP: begin
                w_last = (r_cnt == 6'd3);
            end
            default: begin
                w_raw  = 1'b0;
                w_last = 1'b0;
            end
        endcase
        if (w_stuff) begin
            w_raw  = 1'b0;
            w_last = 1'b0;
        end
    end

    assign w_line_nrzi = w_raw ? r_line_j : ~r_line_j;
    assign w_crc_fb    = r_crc[15] ^ w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_req)  w_state_nxt = c_S_SYNC;
            c_S_SYNC: if (w_last) w_state_nxt = c_S_PID;
            c_S_PID:  if (w_last) w_state_nxt = r_is_data ? c_S_DATA : c_S_EOP;
            c_S_DATA: if (w_last) w_state_nxt = c_S_CRC;
            c_S_CRC:  if (w_last) w_state_nxt = c_S_EOP;
            c_S_EOP:  if (w_last) w_state_nxt = c_S_IDLE;
            default:              w_state_nxt = c_S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = c_S_EOP;
        end
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_ones_nxt    = r_ones;
        w_line_j_nxt  = r_line_j;
        w_crc_nxt     = r_crc;
        w_bus_out_nxt = c_LINE_X;
        w_bus_en_nxt  = 1'b0;
        w_tx_busy_nxt = r_tx_busy;
        w_tx_done_nxt = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_req) begin
                    w_tx_busy_nxt = 1'b1;
                    w_line_j_nxt  = 1'b1;
                    w_crc_nxt     = c_CRC_INIT;
                    w_cnt_nxt     = 6'd0;
                    w_ones_nxt    = 3'd0;
                end
            end
            c_S_SYNC, c_S_PID, c_S_DATA, c_S_CRC: begin
                w_line_j_nxt  = w_line_nrzi;
                w_bus_out_nxt = w_line_nrzi ? c_LINE_J : c_LINE_K;
                w_bus_en_nxt  = 1'b1;
                if (r_state == c_S_SYNC || w_stuff || !w_raw) begin
                    w_ones_nxt = 3'd0;
                end else begin
                    w_ones_nxt = r_ones + 3'd1;
                end
                if (r_state == c_S_DATA && !w_stuff) begin
                    w_crc_nxt = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? c_CRC_POLY : 16'h0000);
                end
                if (w_last) begin
                    w_cnt_nxt = 6'd0;
                end else if (!w_stuff) begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            c_S_EOP: begin
                if (w_stuff) begin
                    // Stuffing left over from the last field goes out before SE0.
                    w_line_j_nxt  = w_line_nrzi;
                    w_bus_out_nxt = w_line_nrzi ? c_LINE_J : c_LINE_K;
                    w_bus_en_nxt  = 1'b1;
                    w_ones_nxt    = 3'd0;
                end else begin
                    w_cnt_nxt = w_last ? 6'd0 : (r_cnt + 6'd1);
                    case (r_cnt)
                        6'd0, 6'd1: begin
                            w_bus_out_nxt = c_LINE_X;
                            w_bus_en_nxt  = 1'b1;
                        end
                        6'd2: begin
                            w_bus_out_nxt = c_LINE_J;
                            w_bus_en_nxt  = 1'b1;
                        end
                        default: begin
                            w_bus_out_nxt = c_LINE_X;
                            w_bus_en_nxt  = 1'b0;
                            w_tx_busy_nxt = 1'b0;
                            w_tx_done_nxt = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                w_cnt_nxt = 6'd0;
            end
        endcase
        // Abort drives the first SE0 immediately and resumes EOP at its second cycle.
        if (w_abort) begin
            w_bus_out_nxt = c_LINE_X;
            w_bus_en_nxt  = 1'b1;
            w_cnt_nxt     = 6'd1;
            w_ones_nxt    = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 6'd0;
            r_ones     <= 3'd0;
            r_line_j   <= 1'b1;
            r_crc      <= c_CRC_INIT;
            r_data     <= 64'd0;
            r_pid_byte <= 8'd0;
            r_is_data  <= 1'b0;
            r_bus_out  <= c_LINE_X;
            r_bus_en   <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_ones     <= w_ones_nxt;
            r_line_j   <= w_line_j_nxt;
            r_crc      <= w_crc_nxt;
            r_bus_out  <= w_bus_out_nxt;
            r_bus_en   <= w_bus_en_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
            r_tx_done  <= w_tx_done_nxt;
            if (r_state == c_S_IDLE && w_req) begin
                r_pid_byte <= {~pid, pid};
                r_is_data  <= send_data;
                if (send_data) begin
                    r_data <= data;
                end
            end
        end
    end

    assign bus_out = r_bus_out;
    assign bus_en  = r_bus_en;
    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

endmodule

`default_nettype wire
